// File: rtl/instr_buffer.sv
// Instruction buffer between fetch and decode/dispatch.
// Circular store of DEPTH fetched instructions. Each cycle it accepts a
// compacted fetch group at the tail, releases up to dispatch_count entries
// from the head, and presents the oldest `N entries to decode.
//
// Ports:
//   clock           single clock, all state updates on its rising edge
//   reset           synchronous, active-high; empties the buffer
//   if_id_packet    fetch group; per-slot valid marks real instructions
//   squash          branch-redirect flush; empties the buffer next cycle
//   dispatch_count  entries consumed from the head this cycle
//   ib_id_packet    oldest `N entries, slot 0 = oldest; valid from occupancy
//   stall           backpressure to fetch (fewer than `N free slots)
//   free_slots      empty slot count
//   entry_count     occupied slot count
//
// DEPTH must be a power of two and at least 2*`N.

`ifndef N
`define N 3
`endif

package instr_buffer_pkg;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
  } IF_ID_PACKET;
endpackage

module instr_buffer
  import instr_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  IF_ID_PACKET [`N-1:0]         if_id_packet,
  input  logic                         squash,
  input  logic [$clog2(`N+1)-1:0]      dispatch_count,
  output IF_ID_PACKET [`N-1:0]         ib_id_packet,
  output logic                         stall,
  output logic [$clog2(DEPTH+1)-1:0]   free_slots,
  output logic [$clog2(DEPTH+1)-1:0]   entry_count
);

  localparam int unsigned NW = `N;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned DW = $clog2(`N+1);

  IF_ID_PACKET   mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [DW-1:0] push_cnt;
  logic [PW-1:0] offs [NW];
  logic [CW-1:0] pop_cnt;
  logic          push_en;

  // Occupancy-derived status; depends on registered state only
  always_comb begin
    free_slots = CW'(DEPTH) - entry_count;
    stall      = (free_slots < CW'(NW));
    push_en    = !stall && !squash;
  end

  // Compaction: each valid slot lands at tail + (number of valid slots before it)
  always_comb begin
    logic [DW-1:0] run;
    run = '0;
    for (int i = 0; i < int'(NW); i++) begin
      offs[i] = PW'(run);
      if (if_id_packet[i].valid) run = run + DW'(1);
    end
    push_cnt = run;
  end

  // Pop never exceeds what is buffered
  always_comb begin
    pop_cnt = (CW'(dispatch_count) < entry_count) ? CW'(dispatch_count) : entry_count;
  end

  // Pointers and occupancy; reset over squash over push/pop
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      head        <= '0;
      tail        <= '0;
      entry_count <= '0;
    end else begin
      head <= head + PW'(pop_cnt);
      if (push_en) begin
        tail        <= tail + PW'(push_cnt);
        entry_count <= entry_count - pop_cnt + CW'(push_cnt);
      end else begin
        entry_count <= entry_count - pop_cnt;
      end
    end
  end

  // Storage is not reset; validity comes only from entry_count
  always_ff @(posedge clock) begin
    if (!reset && push_en) begin
      for (int i = 0; i < int'(NW); i++) begin
        if (if_id_packet[i].valid) mem[tail + offs[i]] <= if_id_packet[i];
      end
    end
  end

  // Head window presented to decode
  always_comb begin
    for (int i = 0; i < int'(NW); i++) begin
      ib_id_packet[i]       = mem[head + PW'(i)];
      ib_id_packet[i].valid = (CW'(i) < entry_count);
    end
  end

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer (N=3, DEPTH=8): table of stimulus
// rows with hand-derived occupancy, plus a queue model of buffered PCs whose
// per-cycle snapshot is queued on drive and compared one cycle later.

`ifndef N
`define N 3
`endif

module tb_instr_buffer;
  import instr_buffer_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned NN    = `N;

  logic                       clock = 1'b0;
  logic                       reset;
  logic                       squash;
  logic [$clog2(NN+1)-1:0]    dispatch_count;
  IF_ID_PACKET [NN-1:0]       if_id_packet;
  IF_ID_PACKET [NN-1:0]       ib_id_packet;
  logic                       stall;
  logic [$clog2(DEPTH+1)-1:0] free_slots;
  logic [$clog2(DEPTH+1)-1:0] entry_count;

  instr_buffer #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .if_id_packet   (if_id_packet),
    .squash         (squash),
    .dispatch_count (dispatch_count),
    .ib_id_packet   (ib_id_packet),
    .stall          (stall),
    .free_slots     (free_slots),
    .entry_count    (entry_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        sq;
    logic [2:0]  vld;
    logic [1:0]  dc;
    logic [31:0] pc0;
    int          exp_cnt;
  } vec_t;

  typedef struct {
    int          cnt;
    logic [31:0] pc [3];
  } snap_t;

  vec_t        tbl [$];
  snap_t       exp_q [$];
  logic [31:0] mq [$];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    snap_t s;
    int    pops;
    logic  pre_stall;
    reset          = v.rst;
    squash         = v.sq;
    dispatch_count = v.dc;
    for (int i = 0; i < int'(NN); i++) begin
      if_id_packet[i].valid = v.vld[i];
      if_id_packet[i].pc    = v.pc0 + 32'(4 * i);
      if_id_packet[i].npc   = v.pc0 + 32'(4 * i + 4);
      if_id_packet[i].inst  = 32'hA500_0000 ^ (v.pc0 + 32'(4 * i));
    end
    #1;
    pre_stall = (mq.size() > int'(DEPTH - NN));
    check($sformatf("stall_pre[%0d]", idx), 64'(stall), 64'(pre_stall));

    // Reference: FIFO of PCs; pop then (if not stalled) append valid slots
    if (v.rst || v.sq) begin
      mq.delete();
    end else begin
      pops = (int'(v.dc) < mq.size()) ? int'(v.dc) : mq.size();
      repeat (pops) void'(mq.pop_front());
      if (!pre_stall)
        for (int i = 0; i < int'(NN); i++)
          if (v.vld[i]) mq.push_back(v.pc0 + 32'(4 * i));
    end
    s.cnt = mq.size();
    for (int i = 0; i < 3; i++) s.pc[i] = (i < s.cnt) ? mq[i] : 32'h0;
    exp_q.push_back(s);

    @(posedge clock);
    #1;
    s = exp_q.pop_front();
    check($sformatf("entry_count[%0d]", idx), 64'(entry_count), 64'(v.exp_cnt));
    check($sformatf("model_count[%0d]", idx), 64'(entry_count), 64'(s.cnt));
    check($sformatf("free_slots[%0d]", idx), 64'(free_slots), 64'(int'(DEPTH) - s.cnt));
    check($sformatf("stall[%0d]", idx), 64'(stall), 64'(s.cnt > int'(DEPTH - NN)));
    for (int i = 0; i < int'(NN); i++) begin
      check($sformatf("valid%0d[%0d]", i, idx), 64'(ib_id_packet[i].valid), 64'(i < s.cnt));
      if (i < s.cnt) begin
        check($sformatf("pc%0d[%0d]", i, idx), 64'(ib_id_packet[i].pc), 64'(s.pc[i]));
        check($sformatf("inst%0d[%0d]", i, idx), 64'(ib_id_packet[i].inst),
              64'(32'hA500_0000 ^ s.pc[i]));
      end
    end
  endtask

  initial begin
    vec_t h;
    reset          = 1'b1;
    squash         = 1'b0;
    dispatch_count = '0;
    if_id_packet   = '0;
    @(posedge clock);
    #1;

    //              rst   sq    vld     dc    pc0        exp
    tbl.push_back('{1'b1, 1'b0, 3'b000, 2'd0, 32'h000, 0});  // reset
    tbl.push_back('{1'b0, 1'b0, 3'b111, 2'd0, 32'h000, 3});  // 0x0,0x4,0x8
    tbl.push_back('{1'b0, 1'b1, 3'b000, 2'd0, 32'h000, 0});  // flush
    tbl.push_back('{1'b0, 1'b0, 3'b101, 2'd0, 32'h010, 2});  // sparse 0x10,0x18
    tbl.push_back('{1'b0, 1'b0, 3'b111, 2'd0, 32'h020, 5});
    tbl.push_back('{1'b0, 1'b0, 3'b100, 2'd0, 32'h028, 6});  // 0x30 only -> stall
    tbl.push_back('{1'b0, 1'b0, 3'b111, 2'd0, 32'h040, 6});  // ignored
    tbl.push_back('{1'b0, 1'b0, 3'b111, 2'd3, 32'h050, 3});  // pop only, push ignored
    tbl.push_back('{1'b0, 1'b0, 3'b111, 2'd3, 32'h060, 3});  // head -> 6
    tbl.push_back('{1'b0, 1'b0, 3'b111, 2'd3, 32'h070, 3});  // across 7->0
    tbl.push_back('{1'b0, 1'b0, 3'b111, 2'd3, 32'h080, 3});
    tbl.push_back('{1'b0, 1'b0, 3'b111, 2'd3, 32'h090, 3});
    tbl.push_back('{1'b0, 1'b0, 3'b111, 2'd3, 32'h0A0, 3});
    tbl.push_back('{1'b0, 1'b0, 3'b111, 2'd2, 32'h0B0, 4});
    tbl.push_back('{1'b0, 1'b1, 3'b111, 2'd2, 32'h0C0, 0});  // squash beats push/pop
    tbl.push_back('{1'b0, 1'b0, 3'b100, 2'd0, 32'h0CC, 1});
    tbl.push_back('{1'b0, 1'b0, 3'b011, 2'd3, 32'h0E0, 2});  // over-pop + push
    tbl.push_back('{1'b0, 1'b0, 3'b000, 2'd2, 32'h000, 0});
    tbl.push_back('{1'b0, 1'b0, 3'b000, 2'd1, 32'h000, 0});  // pop on empty
    tbl.push_back('{1'b0, 1'b0, 3'b111, 2'd0, 32'h0F0, 3});
    tbl.push_back('{1'b1, 1'b0, 3'b111, 2'd1, 32'h100, 0});  // reset beats push/pop
    tbl.push_back('{1'b1, 1'b1, 3'b111, 2'd0, 32'h110, 0});
    tbl.push_back('{1'b0, 1'b0, 3'b011, 2'd0, 32'h120, 2});
    tbl.push_back('{1'b0, 1'b0, 3'b111, 2'd0, 32'h130, 5});
    tbl.push_back('{1'b0, 1'b0, 3'b111, 2'd0, 32'h140, 8});  // full
    tbl.push_back('{1'b0, 1'b0, 3'b111, 2'd3, 32'h150, 5});
    tbl.push_back('{1'b0, 1'b0, 3'b111, 2'd1, 32'h160, 7});
    tbl.push_back('{1'b0, 1'b0, 3'b111, 2'd3, 32'h170, 4});  // stalled, pop only

    foreach (tbl[k]) step(tbl[k], k);

    // Hand sequence: single-entry drain then idle with pop requests
    for (int k = 0; k < 5; k++) begin
      h = '{1'b0, 1'b0, 3'b000, 2'd1, 32'h0, (k < 4) ? 3 - k : 0};
      step(h, 100 + k);
    end
    // Hand sequence: refill after drain wraps cleanly from mid-array pointers
    h = '{1'b0, 1'b0, 3'b110, 2'd0, 32'h200, 2};
    step(h, 200);
    h = '{1'b0, 1'b0, 3'b111, 2'd1, 32'h210, 4};
    step(h, 201);
    h = '{1'b0, 1'b1, 3'b000, 2'd3, 32'h0, 0};
    step(h, 202);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_buffer.md
INSTR_BUFFER -- requirements
Module: instr_buffer

Interface
REQ-001 Parameter: DEPTH, 16, number of buffered instruction slots; SHALL be a power of two and >= 2*`N.
REQ-002 Port: clock  input  1  single clock; all state updates on posedge clock.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: if_id_packet  input  IF_ID_PACKET [`N-1:0]  fetch group from stage_fetch; each slot's valid field marks a real instruction.
REQ-005 Port: squash  input  1  flush request on branch redirect, raised when rob_if_packet reports a mispredict.
REQ-006 Port: dispatch_count  input  $clog2(`N+1)  number of head entries the decode/dispatch side consumes this cycle.
REQ-007 Port: ib_id_packet  output  IF_ID_PACKET [`N-1:0]  oldest `N buffered entries, slot 0 = oldest.
REQ-008 Port: stall  output  1  backpressure to fetch; fetch holds its PC while high.
REQ-009 Port: free_slots  output  $clog2(DEPTH+1)  empty slot count.
REQ-010 Port: entry_count  output  $clog2(DEPTH+1)  occupied slot count.

Function
REQ-011 Storage: circular array of DEPTH IF_ID_PACKET entries; head and tail pointers; registered entry_count.
REQ-012 Pointer wrap: head and tail advance modulo DEPTH; wrap from DEPTH-1 to 0 SHALL preserve program order.
REQ-013 stall = (free_slots < `N); combinational from registered state only, never from same-cycle inputs.
REQ-014 free_slots = DEPTH - entry_count.
REQ-015 Push: when stall=0 and squash=0, valid input slots SHALL be compacted in ascending slot order and written at tail, tail+1, ...; invalid slots are skipped and consume no storage.
REQ-016 Push count = popcount of input valid bits (0..`N); zero valid bits is a legal no-op.
REQ-017 When stall=1, the entire input group SHALL be ignored (no partial write); fetch re-presents it.
REQ-018 Pop: effective pop = min(dispatch_count, entry_count); head advances by effective pop; no underflow.
REQ-019 Push and pop in the same cycle SHALL both take effect: entry_count_next = entry_count - pop + push.
REQ-020 Output: ib_id_packet[i] = entry at head+i (mod DEPTH) with valid=1 when i < entry_count; otherwise valid=0 and other fields don't-care.
REQ-021 Output path is combinational from registers; pushed instructions appear on ib_id_packet the cycle after the push (1-cycle latency); popped entries disappear the cycle after the pop.
REQ-022 Squash: on squash=1, next cycle head=tail=0, entry_count=0; same-cycle push and pop SHALL be discarded.
REQ-023 Squash priority: squash > push/pop; reset > squash.

Reset
REQ-024 On reset=1 at posedge clock: head=0, tail=0, entry_count=0; next cycle stall=0, free_slots=DEPTH, entry_count=0, all ib_id_packet valid=0.
REQ-025 Reset mid-operation SHALL discard all buffered entries regardless of squash, push or pop inputs that cycle.
REQ-026 Storage array contents need not be reset; validity derives solely from entry_count.

Verification (`N=3, DEPTH=8)
REQ-027 Reset, push valid PCs 0x0,0x4,0x8, dispatch_count=0 -> next cycle entry_count=3, ib_id_packet PCs 0x0,0x4,0x8 all valid, free_slots=5, stall=0.
REQ-028 From empty, push valid pattern {1,0,1} PCs 0x10,-,0x18 -> next cycle slot0=0x10, slot1=0x18 valid, slot2 valid=0, entry_count=2.
REQ-029 Fill to entry_count=6 -> stall=1, free_slots=2; present 3 valid -> entry_count stays 6, buffered contents unchanged.
REQ-030 Run push 3/pop 3 for 4 cycles with head starting at 6 -> ib_id_packet order matches push order across index 7->0 wrap; entry_count constant.
REQ-031 entry_count=4, squash=1 with push 3 and dispatch_count=2 -> next cycle entry_count=0, all outputs valid=0, stall=0.
REQ-032 entry_count=1, dispatch_count=3 with push 2 -> next cycle entry_count=2, slot0 = first newly pushed instruction.
